// File: rtl/parking_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared project constants and elaboration-time helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    // Default system clock frequency in Hz.
    localparam int unsigned c_DEFAULT_CLK_F = 40_000_000;

    // Milliseconds per second, used to turn a frequency into ticks per ms.
    localparam int unsigned c_MS_PER_S = 1000;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned reduced;
        result  = 0;
        reduced = (value > 0) ? value - 1 : 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((reduced >> i) != 0) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : parking_pkg

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module   : debounce_channel
// Purpose  : One debounced input: 2-flop synchronizer, stable-time counter,
//            held level register and single-cycle rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel #(
    parameter int unsigned COUNT_TO = 5,
    parameter int unsigned CW       = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_evt_d
);

    localparam logic [CW-1:0] c_CNT_MAX = CW'(COUNT_TO - 1);

    logic          r_s1_q;
    logic          r_s2_q;
    logic [CW-1:0] r_cnt_q;
    logic          r_level_q;
    logic          r_rise_q;
    logic          r_fall_q;

    logic          w_s1_d;
    logic          w_s2_d;
    logic [CW-1:0] w_cnt_d;
    logic          w_level_d;
    logic          w_rise_d;
    logic          w_fall_d;
    logic          w_disagree;

    assign w_disagree = (r_s2_q != r_level_q);

    always_comb begin
        w_s1_d    = i_sig;
        w_s2_d    = r_s1_q;
        w_cnt_d   = '0;
        w_level_d = r_level_q;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;

        // Any agreeing or frozen cycle discards the disagreement run so far.
        if (i_en && w_disagree) begin
            if (r_cnt_q == c_CNT_MAX) begin
                w_level_d = r_s2_q;
                w_rise_d  = r_s2_q;
                w_fall_d  = ~r_s2_q;
            end else begin
                w_cnt_d = r_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_q    <= 1'b0;
            r_s2_q    <= 1'b0;
            r_cnt_q   <= '0;
            r_level_q <= 1'b0;
            r_rise_q  <= 1'b0;
            r_fall_q  <= 1'b0;
        end else begin
            r_s1_q    <= w_s1_d;
            r_s2_q    <= w_s2_d;
            r_cnt_q   <= w_cnt_d;
            r_level_q <= w_level_d;
            r_rise_q  <= w_rise_d;
            r_fall_q  <= w_fall_d;
        end
    end

    assign o_level = r_level_q;
    assign o_rise  = r_rise_q;
    assign o_fall  = r_fall_q;
    // Next-cycle event lets the bank register its OR in step with the pulses.
    assign o_evt_d = w_rise_d | w_fall_d;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/debounce_bank.sv
// ============================================================================
// Module   : debounce_bank
// Purpose  : N_CH independent debounce channels plus a registered any-event
//            flag aligned with the per-channel rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bank
    import parking_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CLK_F  = c_DEFAULT_CLK_F,
    parameter int unsigned DEB_MS = 20
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    input  logic [N_CH-1:0] sig,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_evt
);

    localparam int unsigned COUNT_TO = (CLK_F / c_MS_PER_S) * DEB_MS;
    localparam int unsigned CW       = clog2(COUNT_TO);

    if (COUNT_TO < 2) begin : g_bad_count_to
        $error("debounce_bank: COUNT_TO must be at least 2");
    end

    if ((N_CH < 1) || (N_CH > 32)) begin : g_bad_n_ch
        $error("debounce_bank: N_CH must be in 1..32");
    end

    logic [N_CH-1:0] w_evt_d;
    logic            w_any_evt_d;
    logic            r_any_evt_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel #(
            .COUNT_TO (COUNT_TO),
            .CW       (CW)
        ) u_channel (
            .clk     (CLK),
            .rst_n   (RST),
            .i_en    (en),
            .i_sig   (sig[gi]),
            .o_level (level[gi]),
            .o_rise  (rise[gi]),
            .o_fall  (fall[gi]),
            .o_evt_d (w_evt_d[gi])
        );
    end

    always_comb begin
        w_any_evt_d = |w_evt_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_any_evt_q <= 1'b0;
        end else begin
            r_any_evt_q <= w_any_evt_d;
        end
    end

    assign any_evt = r_any_evt_q;

endmodule : debounce_bank

`default_nettype wire

// File: tb/tb_debounce_bank.sv
// ============================================================================
// Module   : tb_debounce_bank
// Purpose  : Directed and random stimulus for debounce_bank, checked against a
//            sliding-window reference model of the debounce rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_bank;

    localparam int unsigned N_CH     = 4;
    localparam int unsigned CLK_F    = 1000;
    localparam int unsigned DEB_MS   = 5;
    localparam int unsigned COUNT_TO = 5;

    logic            CLK;
    logic            RST;
    logic            en;
    logic [N_CH-1:0] sig;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            any_evt;

    int n_cmp  = 0;
    int n_fail = 0;

    debounce_bank #(
        .N_CH   (N_CH),
        .CLK_F  (CLK_F),
        .DEB_MS (DEB_MS)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .en      (en),
        .sig     (sig),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .any_evt (any_evt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a channel flips once its synchronized input has
    // differed from the held level on each of the last COUNT_TO enabled edges.
    typedef struct packed {
        logic            act;
        logic [N_CH-1:0] s2;
    } hist_t;

    hist_t           hist[$];
    logic [N_CH-1:0] raw[$];
    logic [N_CH-1:0] exp_level = '0;
    logic [N_CH-1:0] exp_rise  = '0;
    logic [N_CH-1:0] exp_fall  = '0;
    logic            exp_evt   = 1'b0;

    initial begin
        raw.push_back('0);
        raw.push_back('0);
    end

    always @(posedge CLK) begin
        logic [N_CH-1:0] s2_now;
        hist_t           h;
        logic            all_dis;
        s2_now   = raw[raw.size()-2];
        exp_rise = '0;
        exp_fall = '0;
        if (!RST) begin
            exp_level = '0;
            hist.delete();
            raw.delete();
            raw.push_back('0);
            raw.push_back('0);
        end else begin
            raw.push_back(sig);
            if (raw.size() > 4) void'(raw.pop_front());
            h.act = en;
            h.s2  = s2_now;
            hist.push_back(h);
            if (hist.size() > COUNT_TO) void'(hist.pop_front());
            for (int ch = 0; ch < N_CH; ch++) begin
                if (hist.size() == COUNT_TO) begin
                    all_dis = 1'b1;
                    for (int k = 0; k < COUNT_TO; k++) begin
                        if (!hist[k].act || (hist[k].s2[ch] == exp_level[ch]))
                            all_dis = 1'b0;
                    end
                    if (all_dis) begin
                        exp_level[ch] = ~exp_level[ch];
                        if (exp_level[ch]) exp_rise[ch] = 1'b1;
                        else               exp_fall[ch] = 1'b1;
                    end
                end
            end
        end
        exp_evt = |(exp_rise | exp_fall);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("level",   32'(level),   32'(exp_level));
        chk("rise",    32'(rise),    32'(exp_rise));
        chk("fall",    32'(fall),    32'(exp_fall));
        chk("any_evt", 32'(any_evt), 32'(exp_evt));
        chk("rise_fall_overlap", 32'(rise & fall), 32'(0));
    endtask

    // Apply inputs away from the edge, take one rising edge, then check.
    task automatic tick(input logic [N_CH-1:0] s, input logic e, input logic r);
        sig = s;
        en  = e;
        RST = r;
        @(posedge CLK);
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_CH-1:0] rs;
        sig = '0;
        en  = 1'b1;
        RST = 1'b0;
        @(negedge CLK);

        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        chk("reset_level", 32'(level), 32'(0));

        // Clean step on channel 0: level appears at edge 7.
        for (int i = 1; i <= 6; i++) tick(4'b0001, 1'b1, 1'b1);
        chk("step_edge6_level0", 32'(level[0]), 32'(0));
        tick(4'b0001, 1'b1, 1'b1);
        chk("step_edge7_level0", 32'(level[0]), 32'(1));
        chk("step_edge7_rise0",  32'(rise[0]),  32'(1));
        chk("step_edge7_anyevt", 32'(any_evt),  32'(1));
        tick(4'b0001, 1'b1, 1'b1);
        chk("step_edge8_rise0",  32'(rise[0]),  32'(0));

        // Short 4-cycle glitch on channel 1 is rejected.
        for (int i = 0; i < 4; i++) tick(4'b0011, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(4'b0001, 1'b1, 1'b1);
        chk("glitch_level1", 32'(level[1]), 32'(0));

        // Bouncing channel 2, then hold high.
        tick(4'b0101, 1'b1, 1'b1);
        tick(4'b0001, 1'b1, 1'b1);
        tick(4'b0101, 1'b1, 1'b1);
        tick(4'b0001, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) tick(4'b0101, 1'b1, 1'b1);
        chk("bounce_edge6_level2", 32'(level[2]), 32'(0));
        tick(4'b0101, 1'b1, 1'b1);
        chk("bounce_edge7_rise2", 32'(rise[2]), 32'(1));

        // All channels together.
        for (int i = 0; i < 8; i++) tick(4'b0000, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) tick(4'b1111, 1'b1, 1'b1);
        chk("all_rise", 32'(rise), 32'(4'b1111));
        for (int i = 1; i <= 7; i++) tick(4'b0000, 1'b1, 1'b1);
        chk("all_fall", 32'(fall), 32'(4'b1111));

        // Enable frozen mid-count on channel 3 restarts the count.
        for (int i = 0; i < 4; i++) tick(4'b1000, 1'b1, 1'b1);
        chk("freeze_pre_level3", 32'(level[3]), 32'(0));
        for (int i = 0; i < 3; i++) tick(4'b1000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(4'b1000, 1'b1, 1'b1);
        chk("freeze_en4_level3", 32'(level[3]), 32'(0));
        tick(4'b1000, 1'b1, 1'b1);
        chk("freeze_en5_level3", 32'(level[3]), 32'(1));

        // Reset mid-count on channel 1 aborts it.
        for (int i = 0; i < 5; i++) tick(4'b1010, 1'b1, 1'b1);
        tick(4'b1010, 1'b1, 1'b0);
        chk("rst_level",   32'(level),   32'(0));
        chk("rst_anyevt",  32'(any_evt), 32'(0));
        for (int i = 1; i <= 6; i++) tick(4'b1010, 1'b1, 1'b1);
        chk("rst_edge6_level1", 32'(level[1]), 32'(0));
        tick(4'b1010, 1'b1, 1'b1);
        chk("rst_edge7_level1", 32'(level[1]), 32'(1));

        // Random phase: sparse toggles, occasional freeze and reset.
        rs = sig;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N_CH; b++) begin
                if ($urandom_range(0, 5) == 0) rs[b] = ~rs[b];
            end
            tick(rs, ($urandom_range(0, 15) != 0), ($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_debounce_bank

`default_nettype wire

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels; legal range 1..32.
REQ-002 Parameter CLK_F, default 40_000_000: clock frequency in Hz.
REQ-003 Parameter DEB_MS, default 20: required stable time in milliseconds.
REQ-004 Derived constant COUNT_TO = (CLK_F/1000)*DEB_MS; elaboration SHALL fail if COUNT_TO < 2.
REQ-005 Derived constant CW = clog2(COUNT_TO): counter width.
REQ-006 CLK  input  1: single clock; all logic on its rising edge.
REQ-007 RST  input  1: reset, synchronous, active-low.
REQ-008 en  input  1: 1 = filtering active; 0 = filtering frozen.
REQ-009 sig  input  N_CH: raw asynchronous inputs, bit i = channel i.
REQ-010 level  output  N_CH: debounced stable level per channel.
REQ-011 rise  output  N_CH: one-cycle pulse when level goes 0->1.
REQ-012 fall  output  N_CH: one-cycle pulse when level goes 1->0.
REQ-013 any_evt  output  1: registered OR of all rise and fall bits, asserted in the same cycle as those bits.

Function
REQ-014 Each channel SHALL pass sig[i] through a 2-flop synchronizer (s1, s2) before any use.
REQ-015 Each channel SHALL keep a CW-bit counter cnt that increments on every edge where en=1 and s2 != level[i].
REQ-016 On an edge where en=1, s2 != level[i] and cnt == COUNT_TO-1, the channel SHALL set level[i] <= s2 and cnt <= 0, and pulse rise[i] or fall[i] for exactly one cycle.
REQ-017 On any edge where s2 == level[i], cnt SHALL clear to 0, so any disagreement shorter than COUNT_TO consecutive cycles is discarded.
REQ-018 Latency: a clean input step SHALL appear on level at rising edge COUNT_TO+2 after the first edge that samples the new value.
REQ-019 rise, fall and any_evt SHALL be 0 in every cycle other than the cycle of a level change; rise[i] and fall[i] SHALL never be 1 together.
REQ-020 While en=0: cnt SHALL clear to 0, level SHALL hold, pulses SHALL be 0, and the synchronizers SHALL keep sampling.
REQ-021 When en rises, the stable-time count SHALL restart from 0; disagreement counted before en fell does not carry over.
REQ-022 Channels SHALL be fully independent; simultaneous level changes on several channels SHALL all pulse in the same cycle.
REQ-023 cnt SHALL never exceed COUNT_TO-1 and SHALL not wrap around.
REQ-024 Unlike the previous block, the bank SHALL track both edges and hold the stable level.

Reset
REQ-025 While RST=0 at a rising edge, s1, s2, cnt, level, rise, fall and any_evt SHALL all go to 0.
REQ-026 Reset asserted mid-count SHALL abort the count with no pulse; after release, the channel SHALL require a full COUNT_TO+2 cycles of a high input before level rises.

Structure
REQ-027 The default CLK_F and the clog2 helper SHALL live in the shared project package parking_pkg; COUNT_TO and CW SHALL be local to the module.
REQ-028 Per-channel logic SHALL be a sub-module debounce_channel (synchronizer, counter, level register, pulses), instantiated N_CH times by a generate loop.
REQ-029 debounce_bank SHALL own only the OR reduction and the registration of any_evt.

Verification (CLK_F=1000, DEB_MS=5 -> COUNT_TO=5, N_CH=4)
REQ-030 sig[0] steps 0->1 and holds -> level[0]=1 and rise[0]=1 for one cycle at edge 7; any_evt=1 in that same cycle.
REQ-031 sig[1] high for 4 cycles then low -> level[1] stays 0; no pulses.
REQ-032 sig[2] bounces 1,0,1,0,1 then holds 1 -> exactly one rise[2], 7 edges after the final 0->1 transition.
REQ-033 sig=4'b1111 stepped at once, then 4'b0000 -> all four rise bits in the same cycle, later all four fall bits together; rise and fall never overlap.
REQ-034 en=0 for 3 cycles mid-count on channel 3, then en=1 -> level[3] changes 5 edges after en returns, not earlier.
REQ-035 RST=0 pulsed at count 3 with sig=1 -> all outputs 0 next edge; level rises 7 edges after RST release.
